mmio_uart_tx: RTL and testbench
===============================

# mmio_uart_tx

Memory-mapped UART transmitter on the single-cycle core's data bus, in parallel with the data memory. It takes the core's store traffic (MemWrite, ALUResult as address, WriteData), queues bytes in a FIFO and serialises them as 8N1 frames. It returns a combinational status word, so the core's load path can read it in the same cycle. The top level muxes ReadData between the data memory and this block using Hit.

## Interface
- BASE_ADDR, default 32'h0000_1000: word-aligned base address. TXDATA is at BASE_ADDR+0, STATUS at BASE_ADDR+4.
- CLKS_PER_BIT, default 16: clock cycles per serial bit. Minimum value 2.
- FIFO_DEPTH, default 8: FIFO entry count. Power of two, minimum 2.
- clk  input  1: single clock; all state updates on the rising edge.
- rst  input  1: asynchronous, active-high reset.
- WriteEnable  input  1: store strobe, driven from the core's MemWrite.
- Addr  input  32: byte address, driven from the core's ALUResult.
- WriteData  input  32: store data.
- ReadData  output  32: combinational. Equals the STATUS word when Addr==BASE_ADDR+4, otherwise 0.
- Hit  output  1: combinational. 1 when Addr equals BASE_ADDR or BASE_ADDR+4.
- TxD  output  1: serial output; idles high.

## Operation
- Address decode is a full 32-bit compare. Any other address, including misaligned ones, is ignored.
- Write to TXDATA (WriteEnable=1, Addr=BASE_ADDR):
  - If the FIFO is not full, push WriteData[7:0]. WriteData[31:8] is ignored.
  - If the FIFO is full, drop the byte and set sticky OVF.
- Write to STATUS with WriteData[3]=1 clears OVF. All other STATUS bits are read-only.
- STATUS word:
  - bit0 BUSY: FIFO non-empty or FSM not IDLE.
  - bit1 FULL.
  - bit2 EMPTY.
  - bit3 OVF.
  - bits[7:4] COUNT: FIFO occupancy, saturating display at 15.
  - bits[31:8] are 0.
- Full and empty are evaluated on pre-edge state. A push while full is dropped even if a pop occurs in the same cycle.
- A simultaneous OVF set and OVF clear leaves OVF set.
- FSM states and transitions:
  - IDLE: TxD=1. If the FIFO is non-empty, pop the head into the shift register, go to START.
  - START: TxD=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: TxD=shift[0], LSB first. After each CLKS_PER_BIT cycles, shift right and increment the index. After 8 bits, go to STOP.
  - STOP: TxD=1 for CLKS_PER_BIT cycles. Then, if the FIFO is non-empty, pop and go straight to START (no idle gap); otherwise go to IDLE.
- Bit timer: a down-counter of width clog2(CLKS_PER_BIT). It reloads to CLKS_PER_BIT-1 on every state entry and on every bit advance.
- FIFO pointers are clog2(FIFO_DEPTH)+1 bits wide and wrap naturally. Full is signalled when the pointers are equal except for the MSB.

## Timing
- Reset values:
  - TxD=1.
  - FSM=IDLE.
  - FIFO empty: EMPTY=1, COUNT=0.
  - OVF=0.
  - Shift register and timer cleared.
- ReadData and Hit reflect reset state immediately, since they are combinational.
- Reset mid-frame forces TxD high immediately (asynchronously). The byte in flight and all queued bytes are lost.
- Push-to-start latency, for a store accepted at edge N with the FSM in IDLE:
  - EMPTY=0 after edge N.
  - At edge N+1 the FSM pops and enters START; TxD falls after edge N+1.
- One frame is exactly 10*CLKS_PER_BIT cycles. Back-to-back queued bytes produce contiguous frames.
- FIFO occupancy changes only on rising edges. ReadData shows post-edge state in the following cycle.

## Test plan
- Reset then idle (CLKS_PER_BIT=4): TxD=1 and STATUS read = 32'h0000_0004 (EMPTY only).
- Single byte: store 32'hDEAD_BEA5 to 0x1000. TxD emits 0, then 1,0,1,0,0,1,0,1 (LSB first), then 1, each bit 4 cycles, start bit beginning one edge after the store. BUSY returns to 0 exactly 40 cycles after TxD falls.
- Back-to-back: store 0x55 then 0x0F on consecutive cycles. Two contiguous frames totalling 80 cycles with no idle high between stop bit 1 and start bit 2.
- Overflow, with FIFO_DEPTH=8 and CLKS_PER_BIT=16:
  - Ten consecutive stores 0x00..0x09. The first pops after one cycle, so seven remain queued plus one added.
  - STATUS shows FULL=1 and OVF=1. Exactly bytes 0x00..0x08 are transmitted; 0x09 is lost.
  - Storing 0x8 to 0x1004 clears OVF.
- Decode: store to 0x1008 and to 0x1001. No push, Hit=0, ReadData=0. Load from 0x1004 gives Hit=1 and the STATUS value.
- Reset mid-frame: assert rst during DATA bit 3. TxD goes to 1 immediately. After release STATUS=32'h4 and no further frame is sent.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA store port, combinational STATUS read,
// byte FIFO feeding a start/data/stop serialiser.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WriteEnable,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Hit,
  output logic        TxD
);

  localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [TW-1:0] RELOAD      = TW'(CLKS_PER_BIT - 1);
  localparam logic [31:0]   STATUS_ADDR = BASE_ADDR + 32'd4;
  localparam logic [PW-1:0] FULL_XOR    = PW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    idx_q, idx_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          txd_q, txd_d;
  logic          ovf_q, ovf_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic          sel_data, sel_status;
  logic          empty, full, push, pop, busy;
  logic [PW-1:0] count;
  logic [3:0]    count_disp;
  logic [31:0]   status;
  logic [7:0]    head;
  logic          unused_wdata;

  assign unused_wdata = ^WriteData[31:8];

  // Address decode and FIFO flags, all from pre-edge state
  always_comb begin
    sel_data   = (Addr == BASE_ADDR);
    sel_status = (Addr == STATUS_ADDR);
    empty      = (wptr_q == rptr_q);
    full       = ((wptr_q ^ rptr_q) == FULL_XOR);
    count      = wptr_q - rptr_q;
    count_disp = (32'(count) > 32'd15) ? 4'hF : 4'(count);
    push       = WriteEnable && sel_data && !full;
    head       = mem_q[rptr_q[AW-1:0]];
    busy       = !empty || (state_q != S_IDLE);
    status     = {24'b0, count_disp, ovf_q, empty, full, busy};
  end

  assign Hit      = sel_data || sel_status;
  assign ReadData = sel_status ? status : 32'h0;
  assign TxD      = txd_q;

  // Overflow flag: set wins over a simultaneous clear
  always_comb begin
    ovf_d = ovf_q;
    if (WriteEnable && sel_status && WriteData[3]) ovf_d = 1'b0;
    if (WriteEnable && sel_data && full)           ovf_d = 1'b1;
  end

  // Serialiser next state; TxD is registered from the next-state values
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          state_d = S_START;
          timer_d = RELOAD;
        end
      end
      S_START: begin
        if (timer_q == '0) begin
          state_d = S_DATA;
          idx_d   = 3'd0;
          timer_d = RELOAD;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_DATA: begin
        if (timer_q == '0) begin
          timer_d = RELOAD;
          shift_d = {1'b0, shift_q[7:1]};
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_STOP: begin
        if (timer_q == '0) begin
          timer_d = RELOAD;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    txd_d  = 1'b1;
    case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase

    wptr_d = wptr_q + PW'(push);
    rptr_d = rptr_q + PW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      timer_q <= '0;
      txd_q   <= 1'b1;
      ovf_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      txd_q   <= txd_d;
      ovf_q   <= ovf_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  // FIFO storage needs no reset; pointers define validity
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= WriteData[7:0];
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: frame-level reference model compared every cycle,
// a serial receiver, and directed checks of latency, overflow, decode and reset.
module tb_mmio_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;
  localparam int FRAME = 10 * CPB;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] STAT = 32'h0000_1004;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        WriteEnable = 1'b0;
  logic [31:0] Addr = 32'h0000_1004;
  logic [31:0] WriteData = 32'h0;
  logic [31:0] ReadData;
  logic        Hit;
  logic        TxD;

  int vectors = 0;
  int errors  = 0;

  // Reference model: queued bytes, byte on the wire, cycle offset within its frame
  logic [7:0] m_q[$];
  logic [7:0] m_cur = 8'h0;
  int         m_pos = -1;
  logic       m_ovf = 1'b0;

  logic [7:0] rx_q[$];

  mmio_uart_tx #(
    .BASE_ADDR   (BASE),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .WriteEnable(WriteEnable),
    .Addr       (Addr),
    .WriteData  (WriteData),
    .ReadData   (ReadData),
    .Hit        (Hit),
    .TxD        (TxD)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_status();
    int n;
    n = m_q.size();
    return {24'b0, 4'((n > 15) ? 15 : n), m_ovf, (n == 0), (n == DEPTH),
            ((n > 0) || (m_pos >= 0))};
  endfunction

  function automatic logic m_txd();
    int b;
    if (m_pos < 0) return 1'b1;
    b = m_pos / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_cur[b-1];
    return 1'b1;
  endfunction

  // Model update on each edge, using pre-edge occupancy for pop/full decisions
  initial begin
    int pre_size;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_q.delete();
        m_cur = 8'h0;
        m_pos = -1;
        m_ovf = 1'b0;
      end else begin
        pre_size = m_q.size();
        if (m_pos < 0 || m_pos == FRAME - 1) begin
          if (pre_size > 0) begin
            m_cur = m_q.pop_front();
            m_pos = 0;
          end else begin
            m_pos = -1;
          end
        end else begin
          m_pos++;
        end
        if (WriteEnable && Addr == BASE) begin
          if (pre_size == DEPTH) m_ovf = 1'b1;
          else m_q.push_back(WriteData[7:0]);
        end else if (WriteEnable && Addr == STAT && WriteData[3]) begin
          m_ovf = 1'b0;
        end
      end
    end
  end

  // Per-cycle compare of all outputs against the model
  initial begin
    forever begin
      @(negedge clk);
      chk("txd", 32'(TxD), 32'(m_txd()));
      chk("hit", 32'(Hit), 32'((Addr == BASE) || (Addr == STAT)));
      chk("rdata", ReadData, (Addr == STAT) ? m_status() : 32'h0);
    end
  end

  // Serial receiver sampling mid-bit; frames cut by reset are discarded
  initial begin
    logic [7:0] rb;
    logic       rok;
    rb = 8'h0;
    forever begin
      @(negedge clk);
      if (TxD === 1'b0 && !rst) begin
        rok = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        if (TxD !== 1'b0 || rst) rok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          rb[i] = TxD;
          if (rst) rok = 1'b0;
        end
        repeat (CPB) @(negedge clk);
        if (TxD !== 1'b1 || rst) rok = 1'b0;
        if (rok) rx_q.push_back(rb);
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    WriteEnable = 1'b1;
    Addr        = a;
    WriteData   = d;
    @(posedge clk);
    #1;
    WriteEnable = 1'b0;
    Addr        = STAT;
    WriteData   = 32'h0;
  endtask

  // Counts negedges with BUSY set, starting at the current one
  task automatic count_busy(output int n, input int limit);
    n = 0;
    while (ReadData[0] === 1'b1 && n < limit) begin
      n++;
      @(negedge clk);
    end
    if (n >= limit) chk("busy_timeout", 32'(ReadData[0]), 32'h0);
  endtask

  initial begin
    int n;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("reset_txd", 32'(TxD), 32'h1);
    chk("reset_status", ReadData, 32'h0000_0004);

    // Single byte 0xA5: start bit one edge after the store, 40-cycle frame
    rx_q.delete();
    sync();
    store(BASE, 32'hDEAD_BEA5);
    @(negedge clk);
    chk("pre_start_txd", 32'(TxD), 32'h1);
    @(negedge clk);
    chk("start_txd", 32'(TxD), 32'h0);
    count_busy(n, 100);
    chk("single_frame_len", 32'(n), 32'd40);
    chk("single_rx_count", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) chk("single_rx_byte", 32'(rx_q[0]), 32'h0000_00A5);

    // Back-to-back 0x55, 0x0F: contiguous frames
    rx_q.delete();
    sync();
    store(BASE, 32'h55);
    store(BASE, 32'h0F);
    @(negedge clk);
    chk("b2b_start_txd", 32'(TxD), 32'h0);
    count_busy(n, 200);
    chk("b2b_len", 32'(n), 32'd80);
    chk("b2b_rx_count", 32'(rx_q.size()), 32'd2);
    if (rx_q.size() == 2) begin
      chk("b2b_rx0", 32'(rx_q[0]), 32'h55);
      chk("b2b_rx1", 32'(rx_q[1]), 32'h0F);
    end

    // Overflow: ten stores, nine accepted, OVF then cleared
    rx_q.delete();
    sync();
    for (int i = 0; i < 10; i++) store(BASE, 32'(i));
    @(negedge clk);
    chk("ovf_status", ReadData, 32'h0000_008B);
    sync();
    store(STAT, 32'h8);
    @(negedge clk);
    chk("ovf_clear_status", ReadData, 32'h0000_0083);
    count_busy(n, 500);
    chk("ovf_rx_count", 32'(rx_q.size()), 32'd9);
    if (rx_q.size() == 9) begin
      for (int i = 0; i < 9; i++) chk("ovf_rx_byte", 32'(rx_q[i]), 32'(i));
    end
    chk("ovf_idle_status", ReadData, 32'h0000_0004);

    // Decode: neighbouring and misaligned addresses are ignored
    rx_q.delete();
    sync();
    Addr = 32'h0000_1008;
    @(negedge clk);
    chk("dec_1008_hit", 32'(Hit), 32'h0);
    chk("dec_1008_rdata", ReadData, 32'h0);
    sync();
    Addr = 32'h0000_1001;
    @(negedge clk);
    chk("dec_1001_hit", 32'(Hit), 32'h0);
    sync();
    store(32'h0000_1008, 32'h77);
    store(32'h0000_1001, 32'h66);
    @(negedge clk);
    chk("dec_load_hit", 32'(Hit), 32'h1);
    chk("dec_load_status", ReadData, 32'h0000_0004);
    repeat (20) @(negedge clk);
    chk("dec_rx_count", 32'(rx_q.size()), 32'd0);

    // Reset during data bit 3 (a zero bit of 0xA5) forces TxD high at once
    rx_q.delete();
    sync();
    store(BASE, 32'hA5);
    @(negedge clk);
    @(negedge clk);
    chk("rst_frame_start", 32'(TxD), 32'h0);
    repeat (17) @(negedge clk);
    chk("pre_rst_txd", 32'(TxD), 32'h0);
    #1 rst = 1'b1;
    #1 chk("rst_async_txd", 32'(TxD), 32'h1);
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_status", ReadData, 32'h0000_0004);
    repeat (60) @(negedge clk);
    chk("post_rst_rx_count", 32'(rx_q.size()), 32'd0);
    chk("post_rst_txd", 32'(TxD), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
